// File: rtl/vga_timing_out_if.sv
// Pixel-generator / VGA-pin bundle for vga_timing_out.
// master: the timing block (drives raster, ticks and pins, reads colour).
// slave:  the pixel generator / board side (drives colour, reads the rest).
interface vga_timing_out_if;
  logic [11:0] rgb_in;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        valid;
  logic        pclk_en;
  logic        line_tick;
  logic        frame_tick;
  logic [15:0] frame_cnt;
  logic        hsync;
  logic        vsync;
  logic [3:0]  vgaRed;
  logic [3:0]  vgaGreen;
  logic [3:0]  vgaBlue;

  modport master (
    input  rgb_in,
    output h_cnt, v_cnt, valid, pclk_en, line_tick, frame_tick, frame_cnt,
    output hsync, vsync, vgaRed, vgaGreen, vgaBlue
  );

  modport slave (
    output rgb_in,
    input  h_cnt, v_cnt, valid, pclk_en, line_tick, frame_tick, frame_cnt,
    input  hsync, vsync, vgaRed, vgaGreen, vgaBlue
  );
endinterface

// File: rtl/vga_timing_out.sv
// VGA raster timing and registered output stage.
// Divides clk down to a pixel strobe, runs the h/v raster counters, and
// registers colour plus hsync/vsync one pixel behind the counters so the
// pins stay mutually aligned. Also provides line/frame ticks and a frame count.
module vga_timing_out #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input logic             clk,
  input logic             rst,
  vga_timing_out_if.master vif
);

  localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG = H_VIS + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_VIS + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;

  // DIV=1 still needs a one-bit register; it simply stays at zero.
  localparam int unsigned  DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [9:0]   H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0]   V_LAST   = 10'(V_TOT - 1);

  logic [DW-1:0] div_q;
  logic          pclk_en;
  logic [9:0]    h_q;
  logic [9:0]    v_q;
  logic          h_wrap;
  logic          v_wrap;
  logic          valid;
  logic          hs_act;
  logic          vs_act;
  logic          line_q;
  logic          frame_q;
  logic [15:0]   frame_cnt_q;
  logic          hsync_q;
  logic          vsync_q;
  logic [11:0]   rgb_q;

  assign pclk_en = (div_q == DIV_LAST);
  assign h_wrap  = (h_q == H_LAST);
  assign v_wrap  = (v_q == V_LAST);
  assign valid   = (h_q < 10'(H_VIS)) && (v_q < 10'(V_VIS));
  assign hs_act  = (h_q >= 10'(HS_BEG)) && (h_q < 10'(HS_END));
  assign vs_act  = (v_q >= 10'(VS_BEG)) && (v_q < 10'(VS_END));

  // Pixel-rate divider: counts 0..DIV-1, strobe on the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (pclk_en) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Raster counters, advanced once per pixel strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pclk_en) begin
      if (h_wrap) begin
        h_q <= '0;
        v_q <= v_wrap ? '0 : v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end
    end
  end

  // Line/frame tick pulses and completed-frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      line_q  <= pclk_en && h_wrap;
      frame_q <= pclk_en && h_wrap && v_wrap;
      if (pclk_en && h_wrap && v_wrap) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  // Output stage: captures the pixel being left, so pins lag counters by one pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      rgb_q   <= '0;
    end else if (pclk_en) begin
      hsync_q <= hs_act ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vs_act ? SYNC_POL : ~SYNC_POL;
      rgb_q   <= valid ? vif.rgb_in : '0;
    end
  end

  assign vif.h_cnt      = h_q;
  assign vif.v_cnt      = v_q;
  assign vif.valid      = valid;
  assign vif.pclk_en    = pclk_en;
  assign vif.line_tick  = line_q;
  assign vif.frame_tick = frame_q;
  assign vif.frame_cnt  = frame_cnt_q;
  assign vif.hsync      = hsync_q;
  assign vif.vsync      = vsync_q;
  assign vif.vgaRed     = rgb_q[11:8];
  assign vif.vgaGreen   = rgb_q[7:4];
  assign vif.vgaBlue    = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing_out.sv
// Testbench for vga_timing_out: two shrunken-geometry instances (DIV=3 active-low
// sync, DIV=1 active-high sync) checked every clock against an arithmetic model
// that derives the raster position from the number of clocks since reset.
module tb_vga_timing_out;

  typedef struct {
    int unsigned div;
    int unsigned hv, hf, hs, hb;
    int unsigned vv, vf, vs, vb;
    bit          pol;
  } geo_t;

  typedef struct {
    bit          hs;
    bit          vs;
    logic [11:0] rgb;
  } pins_t;

  localparam geo_t GA = '{div: 3, hv: 8, hf: 2, hs: 3, hb: 2,
                          vv: 5, vf: 1, vs: 2, vb: 1, pol: 1'b0};
  localparam geo_t GB = '{div: 1, hv: 6, hf: 1, hs: 2, hb: 1,
                          vv: 4, vf: 1, vs: 1, vb: 1, pol: 1'b1};

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] rgb_drv;
  bit          pat_mode;
  bit          const_mode;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned k;
  pins_t pins_a;
  pins_t pins_b;

  always #5 clk = ~clk;

  vga_timing_out_if ifa ();
  vga_timing_out_if ifb ();

  assign ifa.rgb_in = pat_mode ? {ifa.h_cnt[3:0], ifa.v_cnt[3:0], 4'h5} : rgb_drv;
  assign ifb.rgb_in = pat_mode ? {ifb.h_cnt[3:0], ifb.v_cnt[3:0], 4'h5} : rgb_drv;

  vga_timing_out #(
    .DIV(3), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(5), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) u_a (
    .clk(clk),
    .rst(rst),
    .vif(ifa)
  );

  vga_timing_out #(
    .DIV(1), .H_VIS(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) u_b (
    .clk(clk),
    .rst(rst),
    .vif(ifb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic pins_t reset_pins(input geo_t g);
    pins_t p;
    p.hs  = !g.pol;
    p.vs  = !g.pol;
    p.rgb = 12'h000;
    return p;
  endfunction

  // Expected pins after a strobe edge taken during clock cycle kk.
  function automatic pins_t next_pins(input geo_t g, input int unsigned kk);
    pins_t p;
    int unsigned ht, vt, n, h, v;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    n  = kk / g.div;
    h  = n % ht;
    v  = (n / ht) % vt;
    p.hs = (h >= g.hv + g.hf && h < g.hv + g.hf + g.hs) ? g.pol : !g.pol;
    p.vs = (v >= g.vv + g.vf && v < g.vv + g.vf + g.vs) ? g.pol : !g.pol;
    if (h < g.hv && v < g.vv) begin
      p.rgb = pat_mode ? {h[3:0], v[3:0], 4'h5} : rgb_drv;
    end else begin
      p.rgb = 12'h000;
    end
    return p;
  endfunction

  task automatic check_dut(input string nm, input geo_t g, input int unsigned kk,
                           input logic [9:0] h_o, input logic [9:0] v_o,
                           input logic valid_o, input logic pclk_o,
                           input logic lt_o, input logic ft_o,
                           input logic [15:0] fc_o, input logic hs_o, input logic vs_o,
                           input logic [11:0] rgb_o, input pins_t p);
    int unsigned ht, vt, n, h, v, fr;
    bit wrapped;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    n  = kk / g.div;
    h  = n % ht;
    v  = (n / ht) % vt;
    fr = (n / (ht * vt)) % 65536;
    wrapped = (kk > 0) && (kk % g.div == 0) && (h == 0);
    chk({nm, ".h_cnt"},      32'(h_o),     h);
    chk({nm, ".v_cnt"},      32'(v_o),     v);
    chk({nm, ".valid"},      32'(valid_o), 32'(h < g.hv && v < g.vv));
    chk({nm, ".pclk_en"},    32'(pclk_o),  32'(kk % g.div == g.div - 1));
    chk({nm, ".line_tick"},  32'(lt_o),    32'(wrapped));
    chk({nm, ".frame_tick"}, 32'(ft_o),    32'(wrapped && v == 0));
    chk({nm, ".frame_cnt"},  32'(fc_o),    fr);
    chk({nm, ".hsync"},      32'(hs_o),    32'(p.hs));
    chk({nm, ".vsync"},      32'(vs_o),    32'(p.vs));
    chk({nm, ".rgb"},        32'(rgb_o),   32'(p.rgb));
  endtask

  task automatic check_both();
    check_dut("A", GA, k, ifa.h_cnt, ifa.v_cnt, ifa.valid, ifa.pclk_en,
              ifa.line_tick, ifa.frame_tick, ifa.frame_cnt, ifa.hsync, ifa.vsync,
              {ifa.vgaRed, ifa.vgaGreen, ifa.vgaBlue}, pins_a);
    check_dut("B", GB, k, ifb.h_cnt, ifb.v_cnt, ifb.valid, ifb.pclk_en,
              ifb.line_tick, ifb.frame_tick, ifb.frame_cnt, ifb.hsync, ifb.vsync,
              {ifb.vgaRed, ifb.vgaGreen, ifb.vgaBlue}, pins_b);
  endtask

  // One running clock cycle: check mid-cycle, set stimulus, advance the model.
  task automatic run_cycles(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      #1;
      check_both();
      if (!pat_mode) rgb_drv = const_mode ? 12'hABC : 12'($urandom);
      if (k % GA.div == GA.div - 1) pins_a = next_pins(GA, k);
      if (k % GB.div == GB.div - 1) pins_b = next_pins(GB, k);
      k++;
      @(negedge clk);
    end
  endtask

  // Cycles with rst held high: model stays at the reset point.
  task automatic hold_reset(input int unsigned cycles);
    k      = 0;
    pins_a = reset_pins(GA);
    pins_b = reset_pins(GB);
    for (int unsigned i = 0; i < cycles; i++) begin
      #1;
      check_both();
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    rgb_drv    = 12'h000;
    pat_mode   = 1'b0;
    const_mode = 1'b0;
    @(negedge clk);
    hold_reset(3);

    // Random colour over three frames of A and many frames of B.
    rst = 1'b0;
    k   = 0;
    run_cycles(1300);

    // Constant colour with blanking.
    const_mode = 1'b1;
    run_cycles(420);

    // Position-derived pattern for alignment.
    const_mode = 1'b0;
    pat_mode   = 1'b1;
    run_cycles(450);

    // Asynchronous reset in the middle of a frame, then resume.
    rst = 1'b1;
    hold_reset(3);
    rst = 1'b0;
    k   = 0;
    run_cycles(500);
    pat_mode = 1'b0;
    run_cycles(450);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
